ntru_sample_iid_stream: RTL and testbench
=========================================

# ntru_sample_iid_stream

Ternary message sampler for the Encaps datapath, sitting directly upstream of the lift stage. It consumes uniform random bytes and reduces each byte mod 3 to a ternary coefficient. It assembles the full 701-coefficient message polynomial m, with coefficient 700 forced to 0, and then replays m as a gapless stream of two coefficients per cycle on the lift stage's `m_in`/`en` inputs. The assembled polynomial is also exposed in parallel for message packing and hashing.

## Interface
- `NTRU_N`, 701: polynomial length.
- `M_BITS`, 1402: 2·NTRU_N, width of the packed ternary polynomial.
- `PAIRS`, 351: ceil(NTRU_N/2), number of stream beats.
- `CNT_BITS`, 9: width of the beat and handshake counters.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle request to sample a new m; honoured only in IDLE.
- `rnd_data`  in  16  two random bytes; `[8:1]` is the even coefficient, `[16:9]` is the odd coefficient.
- `rnd_valid`  in  1  `rnd_data` is valid.
- `rnd_ready`  out  1  the block accepts `rnd_data` this cycle.
- `m_out`  out  4  stream beat; `[2:1]` is coeff 2j, `[4:3]` is coeff 2j+1. Drives the lift stage's `m_in`.
- `m_en`  out  1  stream beat valid. Drives the lift stage's `en`.
- `m_poly`  out  M_BITS  parallel m; `m_poly[2i+2:2i+1]` is coeff i.
- `busy`  out  1  high when not in IDLE.
- `done`  out  1  one-cycle pulse after the last stream beat.

## Operation
- Ternary encoding: 2'b00 = 0, 2'b01 = +1, 2'b10 = −1. 2'b11 is never produced.
- Coefficient from byte b:
  - r = b mod 3, computed exactly for all 0..255.
  - r=0 → 2'b00, r=1 → 2'b01, r=2 → 2'b10.
- FSM states:
  - IDLE: `rnd_ready`=0, `m_en`=0. `start` → FILL; clear counter k and all of `m_poly` on entry.
  - FILL: `rnd_ready`=1.
    - Each cycle with `rnd_valid`&&`rnd_ready`, write coeffs 2k and 2k+1, then k++.
    - Cycles with `rnd_valid`=0 hold all state.
    - The handshake at k=349 writes coeffs 698 and 699, forces coeff 700 to 2'b00, and transitions to STREAM with beat counter j=0.
    - Exactly 350 handshakes are consumed per run.
  - STREAM: `m_en`=1, `m_out` = {coeff 2j+1, coeff 2j}, j++ every cycle.
    - Nothing can stall this state; `rnd_valid` is ignored.
    - At j=350, `m_out[2:1]` = coeff 700 (00) and `m_out[4:3]` = 2'b00 pad. Transition to DONE.
  - DONE: `done`=1 for one cycle, then IDLE. `m_poly` holds until the next `start`.
- `start` outside IDLE is ignored. `rnd_data` outside FILL is ignored, with no write.
- `m_out` is 4'b0 whenever `m_en`=0.

## Timing
- Reset value of every output is 0, including `m_poly`. This is reached on the first rising edge with `rst`=1.
- Reset from any state, including mid-FILL or mid-STREAM, returns the block to IDLE and clears k, j and `m_poly`. The downstream lift stage is reset by the same `rst`.
- `rnd_ready` and `m_en` are decoded combinationally from the state register. `m_out` is a mux of `m_poly` indexed by j. No combinational path runs from `rnd_valid` to `rnd_ready`.
- `start` sampled at edge E puts the block in FILL from E+1. With `rnd_valid` held high, the last handshake occurs at E+350.
- STREAM starts the cycle after the last handshake. `m_en` is high for exactly 351 consecutive cycles, and `done` is high on the following cycle.
- Minimum run time from `start` to `done` is 702 cycles.

## Test plan
- All `rnd_data`=16'h0000, `rnd_valid` held high → exactly 350 handshakes, `m_poly`=0, 351 `m_en` beats with `m_out`=0, and `done` 702 cycles after `start`.
- Bytes 0x01,0x02 / 0xFF,0xFE / 0x03,0x04 fed as the first three beats → coeffs 0..5 = 01,10,00,10,00,01; on `m_out`, beat 0 = 4'b1001 and beat 1 = 4'b1000.
- `rnd_valid` toggled 1-0-1 pseudo-randomly → `m_poly` is identical to the gapless case, and `m_en` is still 351 contiguous cycles with no gap.
- Exhaustive byte sweep 0..255 across coefficient positions, checked against a b%3 model → all 700 coeffs match, coeff 700 is 00, and the final beat `m_out` = 4'b0000.
- `rst` asserted at STREAM beat j=100 → the next cycle shows `m_en`=0, `m_out`=0, `m_poly`=0, `busy`=0, and no `done` pulse. A new `start` then completes normally.
- `start` pulsed during FILL and during STREAM → ignored: the handshake count stays 350 and there is a single `done` pulse.

Source files
------------

// File: rtl/ntru_sample_iid_stream.sv
// Ternary message sampler: reduces random bytes mod 3 into the 701-coefficient
// polynomial m, then replays m as a gapless two-coefficient-per-cycle stream.
module ntru_sample_iid_stream #(
    parameter int NTRU_N   = 701,
    parameter int M_BITS   = 1402,
    parameter int PAIRS    = 351,
    parameter int CNT_BITS = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       rnd_data,
    input  logic              rnd_valid,
    output logic              rnd_ready,
    output logic [3:0]        m_out,
    output logic              m_en,
    output logic [M_BITS-1:0] m_poly,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state_o
);

    localparam logic [CNT_BITS-1:0] LAST_K = CNT_BITS'((NTRU_N - 1) / 2 - 1);
    localparam logic [CNT_BITS-1:0] LAST_J = CNT_BITS'(PAIRS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_BITS-1:0] k_q;
    logic [CNT_BITS-1:0] j_q;
    logic [M_BITS-1:0]   poly_q;
    logic [M_BITS+1:0]   poly_pad;
    logic [3:0]          pair_d;

    // Byte mod 3 via base-4 digit sum (4 == 1 mod 3); result is already the
    // ternary code: 0 -> 00, 1 -> 01, 2 -> 10.
    function automatic logic [1:0] trit_of_byte(input logic [7:0] b);
        logic [3:0] s1;
        logic [2:0] s2;
        logic [1:0] r;
        s1 = 4'(b[1:0]) + 4'(b[3:2]) + 4'(b[5:4]) + 4'(b[7:6]);
        s2 = 3'(s1[1:0]) + 3'(s1[3:2]);
        if (s2 >= 3'd6) begin
            r = 2'(s2 - 3'd6);
        end else if (s2 >= 3'd3) begin
            r = 2'(s2 - 3'd3);
        end else begin
            r = s2[1:0];
        end
        return r;
    endfunction

    assign pair_d = {trit_of_byte(rnd_data[15:8]), trit_of_byte(rnd_data[7:0])};

    // Handshake: a beat of rnd_data transfers on a rising edge where
    // rnd_valid && rnd_ready; rnd_ready depends only on the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            j_q     <= '0;
            poly_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FILL;
                        k_q     <= '0;
                        j_q     <= '0;
                        poly_q  <= '0;
                    end
                end
                S_FILL: begin
                    if (rnd_valid) begin
                        poly_q[{k_q, 2'b00} +: 4] <= pair_d;
                        if (k_q == LAST_K) begin
                            poly_q[M_BITS-1 -: 2] <= 2'b00;
                            j_q     <= '0;
                            state_q <= S_STREAM;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    j_q <= j_q + 1'b1;
                    if (j_q == LAST_J) begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The final beat reads coeff 700 plus a zero pad beyond the polynomial.
    assign poly_pad    = {2'b00, poly_q};
    assign rnd_ready   = (state_q == S_FILL);
    assign m_en        = (state_q == S_STREAM);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign m_poly      = poly_q;
    assign m_out       = m_en ? poly_pad[{j_q, 2'b00} +: 4] : 4'b0000;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ntru_sample_iid_stream.sv
// Self-checking bench for ntru_sample_iid_stream: byte-level b%3 model, beat
// scoreboard fed at each handshake, and per-run count/latency checks.
module tb_ntru_sample_iid_stream;

    localparam int N  = 701;
    localparam int MB = 1402;
    localparam int NB = 350;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   rnd_data;
    logic          rnd_valid;
    logic          rnd_ready;
    logic [3:0]    m_out;
    logic          m_en;
    logic [MB-1:0] m_poly;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    ntru_sample_iid_stream dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rnd_data    (rnd_data),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .m_out       (m_out),
        .m_en        (m_en),
        .m_poly      (m_poly),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] tm(input logic [7:0] b);
        case (int'(b) % 3)
            0:       return 2'b00;
            1:       return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    // Scoreboard and monitor state (written only by the monitor)
    logic [3:0] exp_q[$];
    int         cyc       = 0;
    int         hs_cnt    = 0;
    int         beat_cnt  = 0;
    int         beat_idx  = 0;
    int         en_runs   = 0;
    int         done_cnt  = 0;
    int         done_cyc  = 0;
    int         bad_idle  = 0;
    logic       prev_en   = 1'b0;
    logic [3:0] beat_log[0:NB];

    logic [7:0]    src[0:2*NB-1];
    logic [MB-1:0] poly_a;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [4:0] e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rnd_valid && rnd_ready) begin
                exp_q.push_back({tm(rnd_data[15:8]), tm(rnd_data[7:0])});
                hs_cnt++;
                if (hs_cnt % NB == 0) exp_q.push_back(4'b0000);
            end
            if (m_en) begin
                if (!prev_en) begin
                    en_runs++;
                    beat_idx = 0;
                end
                if (beat_idx <= NB) beat_log[beat_idx] = m_out;
                beat_idx++;
                beat_cnt++;
                e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 5'h10;
                check_eq("beat", {27'd0, 1'b0, m_out}, {27'd0, e});
            end else if (m_out != 4'b0000) begin
                bad_idle++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_en = m_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int count_mis(input logic [MB-1:0] a, input logic [MB-1:0] b);
        int n = 0;
        for (int i = 0; i < N; i++) if (a[2*i +: 2] !== b[2*i +: 2]) n++;
        return n;
    endfunction

    // One full sampling run from src[]; optional valid gaps, stray start
    // pulses, or a reset at stream beat rst_beat (>=0).
    task automatic run(input bit gaps, input bit poke_start, input int rst_beat, input bit chk_lat);
        int hs0 = hs_cnt;
        int bt0 = beat_cnt;
        int rn0 = en_runs;
        int dn0 = done_cnt;
        int bd0 = bad_idle;
        int c0;
        int waited;
        logic [MB-1:0] ep = '0;
        for (int i = 0; i < 2 * NB; i++) ep[2*i +: 2] = tm(src[i]);

        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                    rnd_valid = 1'b0;
                    rnd_data  = 16'($urandom);
                    tick();
                end
            end
            rnd_valid = 1'b1;
            rnd_data  = {src[2*i+1], src[2*i]};
            start     = poke_start && (i == 100);
            tick();
            start = 1'b0;
        end
        rnd_valid = 1'b1;
        rnd_data  = 16'hFFFF;

        if (rst_beat >= 0) begin
            repeat (rst_beat) tick();
            rst = 1'b1;
            tick();
            check_eq("rst_m_en",   32'(m_en), 0);
            check_eq("rst_m_out",  32'(m_out), 0);
            check_eq("rst_m_poly", 32'(|m_poly), 0);
            check_eq("rst_busy",   32'(busy), 0);
            rst       = 1'b0;
            rnd_valid = 1'b0;
            repeat (5) tick();
            check_eq("rst_no_done", done_cnt - dn0, 0);
            check_eq("rst_beats",   beat_cnt - bt0, rst_beat);
            return;
        end

        for (waited = 0; waited < 800 && done_cnt == dn0; waited++) begin
            start = poke_start && (waited == 50);
            tick();
            start = 1'b0;
        end
        rnd_valid = 1'b0;
        repeat (3) tick();
        check_eq("done_pulses", done_cnt - dn0, 1);
        check_eq("handshakes",  hs_cnt - hs0, NB);
        check_eq("beats",       beat_cnt - bt0, NB + 1);
        check_eq("en_runs",     en_runs - rn0, 1);
        check_eq("idle_m_out",  bad_idle - bd0, 0);
        check_eq("q_left",      exp_q.size(), 0);
        check_eq("busy_after",  32'(busy), 0);
        check_eq("poly_mis",    count_mis(m_poly, ep), 0);
        check_eq("coef700",     32'(m_poly[MB-1 -: 2]), 0);
        check_eq("last_beat",   32'(beat_log[NB]), 0);
        if (chk_lat) check_eq("latency", done_cyc - c0, 702);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        rnd_valid = 1'b0;
        rnd_data  = '0;
        tick();
        check_eq("rst_ready", 32'(rnd_ready), 0);
        check_eq("rst_en",    32'(m_en), 0);
        check_eq("rst_out",   32'(m_out), 0);
        check_eq("rst_poly",  32'(|m_poly), 0);
        check_eq("rst_busy0", 32'(busy), 0);
        check_eq("rst_done0", 32'(done), 0);
        rst = 1'b0;
        tick();

        // All-zero bytes, gapless
        for (int i = 0; i < 2 * NB; i++) src[i] = 8'h00;
        run(1'b0, 1'b0, -1, 1'b1);
        check_eq("zero_poly", 32'(|m_poly), 0);

        // Directed first bytes, random remainder
        for (int i = 0; i < 2 * NB; i++) src[i] = 8'($urandom);
        src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'hFF;
        src[3] = 8'hFE; src[4] = 8'h03; src[5] = 8'h04;
        run(1'b0, 1'b0, -1, 1'b1);
        check_eq("coef0_5", 32'(m_poly[11:0]), 32'b0100_1000_1001);
        check_eq("beat0",   32'(beat_log[0]), 32'b1001);
        check_eq("beat1",   32'(beat_log[1]), 32'b1000);
        poly_a = m_poly;

        // Same data with random valid gaps
        run(1'b1, 1'b0, -1, 1'b0);
        check_eq("gap_vs_gapless", count_mis(m_poly, poly_a), 0);

        // Byte sweep 0..255 across positions
        for (int i = 0; i < 2 * NB; i++) src[i] = 8'(i % 256);
        run(1'b0, 1'b0, -1, 1'b1);

        // Reset mid-stream, then a normal run
        for (int i = 0; i < 2 * NB; i++) src[i] = 8'($urandom);
        run(1'b0, 1'b0, 100, 1'b0);
        run(1'b0, 1'b0, -1, 1'b1);

        // Stray start pulses during FILL and STREAM
        for (int i = 0; i < 2 * NB; i++) src[i] = 8'($urandom_range(0, 255));
        run(1'b0, 1'b1, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
